fibonacci_bcd_engine: RTL and testbench
=======================================

Name: fibonacci_bcd_engine

Overview:
- Self-contained engine that takes an iteration count n as packed BCD and computes the Fibonacci number fib(n), where fib(0)=0 and fib(1)=1.
- It returns fib(n) as packed BCD, with a start/ready/done handshake.
- Digit counts are parametrised. Results that do not fit the output width are detected and the computation terminates early. Non-decimal input digits are rejected.
- It sits between the debounced start pulse / switch inputs and the seven-segment multiplexer in the display top level.

Parameters:
- IN_DIGITS, 2, number of BCD digits of n (legal 1..3).
- OUT_DIGITS, 4, number of BCD digits of the result (legal 1..8).
- Derived, not overridable:
  - LIMIT = 10^OUT_DIGITS - 1.
  - W = clog2(LIMIT+1), the binary result width (14 for defaults).
  - NW = clog2(10^IN_DIGITS), the iteration counter width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  single-cycle request; accepted only while ready_o=1.
- n_bcd_i  in  4*IN_DIGITS  iteration count, packed BCD, most significant digit in the MSBs.
- ready_o  out  1  high in IDLE only.
- done_o  out  1  one-cycle pulse when the result registers update.
- bcd_o  out  4*OUT_DIGITS  result, packed BCD; held between jobs.
- overflow_o  out  1  last job exceeded LIMIT; held.
- error_o  out  1  last job had a BCD input digit >9; held.

Behaviour:
- Reset (asynchronous): state=IDLE, ready_o=1, done_o=0, bcd_o=0, overflow_o=0, error_o=0, all internal registers=0. Reset mid-job aborts the job immediately.
- States: IDLE, BCD2BIN, FIB, BIN2BCD, DONE.
- IDLE:
  - On start_i=1, capture n_bcd_i and clear the accumulator.
  - Next state is BCD2BIN. ready_o drops in the following cycle.
  - start_i in any other state is ignored; there is no queueing.
  - n_bcd_i changes after the capture cycle have no effect.
- BCD2BIN:
  - Exactly IN_DIGITS cycles, one digit per cycle, MSB digit first: acc <= acc*10 + digit.
  - Any digit >9 sets an internal error flag. The remaining digits are still consumed (fixed timing).
  - At exit: if the error flag is set, go to DONE. Otherwise load counter=acc, a=0, b=1, and go to FIB.
- FIB:
  - Datapath a, b is W+2 bits wide, which cannot wrap before detection.
  - Each cycle, decisions are evaluated in this priority order:
    1. If a > LIMIT: set overflow, go to DONE.
    2. Else if counter==0: go to BIN2BCD.
    3. Else: a <= b, b <= a+b, counter <= counter-1.
  - Occupancy is n+1 cycles without overflow, or k+1 cycles with overflow, where k is the first index with fib(k) > LIMIT. Overflow therefore terminates early.
- BIN2BCD:
  - Double-dabble over a[W-1:0]: exactly W cycles.
  - Each cycle, add 3 to every digit ≥5, then shift left one bit, MSB first.
- DONE, one cycle:
  - done_o=1 and ready_o=0.
  - Results are registered on entry to this state:
    - Normal: bcd_o = converted value, overflow_o=0, error_o=0.
    - Overflow: bcd_o = all digits 9, overflow_o=1, error_o=0.
    - Error: bcd_o keeps its previous value, error_o=1, overflow_o=0.
  - Next state is IDLE. start_i is accepted on the cycle after DONE at the earliest.
- Latency, measured from the first BCD2BIN cycle = index 0 to the done_o cycle:
  - Normal: IN_DIGITS + n + 1 + W.
  - Overflow: IN_DIGITS + k + 1.
  - Error: IN_DIGITS.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan (defaults IN_DIGITS=2, OUT_DIGITS=4, W=14):
- After reset: ready_o=1, done_o=0, bcd_o=0x0000, overflow_o=0, error_o=0. Then start with n_bcd_i=0x10 → done_o pulses at index 27, bcd_o=0x0055, flags 0, ready_o=1 on the next cycle.
- n=0x00 → bcd_o=0x0000 at index 17. n=0x01 → bcd_o=0x0001 at index 18. n=0x20 → bcd_o=0x6765 at index 37, overflow_o=0.
- n=0x21 → overflow_o=1, bcd_o=0x9999, done at index 24. n=0x99 → the same result, also at index 24 (early termination).
- Prior result 0x0055, then n_bcd_i=0x1A → error_o=1, overflow_o=0, bcd_o stays 0x0055, done at index 2.
- Pulse start_i during FIB and again during DONE, and toggle n_bcd_i after acceptance → both pulses ignored, result unaffected, exactly one done_o per accepted start.
- Assert reset_i mid-FIB → outputs return to reset values asynchronously. A new job with n=0x05 then yields 0x0005 at index 22.

Source files
------------

// File: rtl/fibonacci_bcd_engine.sv
// Fibonacci engine: packed-BCD n in, packed-BCD fib(n) out, start/ready/done handshake.
// Latency from first BCD2BIN cycle: IN_DIGITS+n+1+W normal, IN_DIGITS+k+1 overflow, IN_DIGITS error.
// Backpressure: none; start_i only accepted while ready_o=1, other starts are dropped (no queue).
// Ports:
//   clk_i, reset_i         clock, asynchronous active-high reset
//   start_i, n_bcd_i       job request and packed-BCD iteration count (MSD in MSBs)
//   ready_o, done_o        idle indicator, one-cycle result-update pulse
//   bcd_o, overflow_o, error_o  held result and status of the last job
module fibonacci_bcd_engine #(
    parameter int IN_DIGITS  = 2,
    parameter int OUT_DIGITS = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [4*IN_DIGITS-1:0]  n_bcd_i,
    output logic                    ready_o,
    output logic                    done_o,
    output logic [4*OUT_DIGITS-1:0] bcd_o,
    output logic                    overflow_o,
    output logic                    error_o
);

    function automatic int unsigned pow10(input int d);
        int unsigned p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    localparam int unsigned LIMIT = pow10(OUT_DIGITS) - 1;
    localparam int W  = $clog2(LIMIT + 1);
    localparam int NW = $clog2(pow10(IN_DIGITS));
    localparam int SW = $clog2(W + 1);
    localparam logic [W+1:0] LIMIT_V = (W+2)'(LIMIT);

    typedef enum logic [2:0] {S_IDLE, S_BCD2BIN, S_FIB, S_BIN2BCD, S_DONE} state_t;

    state_t                  r_state, w_next;
    logic [4*IN_DIGITS-1:0]  r_n;
    logic [NW-1:0]           r_acc, r_ctr;
    logic [W+1:0]            r_a, r_b;
    logic [W-1:0]            r_bin;
    logic [4*OUT_DIGITS-1:0] r_dd;
    logic [SW-1:0]           r_step;
    logic                    r_err;
    logic                    r_ready, r_done, r_ovf, r_errq;
    logic [4*OUT_DIGITS-1:0] r_bcd;

    logic [3:0]              w_digit;
    logic                    w_err_next;
    logic [NW+3:0]           w_mul;
    logic [NW-1:0]           w_acc_next;
    logic                    w_in_last, w_dd_last, w_fib_ovf, w_ctr_zero;
    logic [4*OUT_DIGITS-1:0] w_adj, w_dd_next;

    // Digits are consumed from the top nibble; r_n shifts left each cycle.
    always_comb begin
        w_digit    = r_n[4*IN_DIGITS-1 -: 4];
        w_err_next = r_err | (w_digit > 4'd9);
        w_mul      = (NW+4)'(r_acc) * (NW+4)'(10) + (NW+4)'(w_digit);
        w_acc_next = NW'(w_mul);
        w_in_last  = (r_step == SW'(IN_DIGITS - 1));
        w_dd_last  = (r_step == SW'(W - 1));
        w_fib_ovf  = (r_a > LIMIT_V);
        w_ctr_zero = (r_ctr == '0);
        w_adj      = r_dd;
        for (int i = 0; i < OUT_DIGITS; i++) begin
            if (r_dd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_dd[4*i +: 4] + 4'd3;
        end
        // Top bit of the adjusted value falls off: the result always fits.
        w_dd_next = (4*OUT_DIGITS)'({w_adj, r_bin[W-1]});
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start_i) w_next = S_BCD2BIN;
            S_BCD2BIN: if (w_in_last) w_next = w_err_next ? S_DONE : S_FIB;
            S_FIB: begin
                // Overflow check has priority so an early-out can't be masked by counter==0.
                if (w_fib_ovf)       w_next = S_DONE;
                else if (w_ctr_zero) w_next = S_BIN2BCD;
            end
            S_BIN2BCD: if (w_dd_last) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_n     <= '0;
            r_acc   <= '0;
            r_ctr   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_bin   <= '0;
            r_dd    <= '0;
            r_step  <= '0;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_errq  <= 1'b0;
        end else begin
            r_ready <= (w_next == S_IDLE);
            r_done  <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_n    <= n_bcd_i;
                        r_acc  <= '0;
                        r_err  <= 1'b0;
                        r_step <= '0;
                    end
                end
                S_BCD2BIN: begin
                    r_acc  <= w_acc_next;
                    r_err  <= w_err_next;
                    r_n    <= r_n << 4;
                    r_step <= r_step + SW'(1);
                    if (w_in_last) begin
                        if (w_err_next) begin
                            r_errq <= 1'b1;
                            r_ovf  <= 1'b0;
                        end else begin
                            r_ctr <= w_acc_next;
                            r_a   <= '0;
                            r_b   <= (W+2)'(1);
                        end
                    end
                end
                S_FIB: begin
                    if (w_fib_ovf) begin
                        r_bcd  <= {OUT_DIGITS{4'h9}};
                        r_ovf  <= 1'b1;
                        r_errq <= 1'b0;
                    end else if (w_ctr_zero) begin
                        r_bin  <= r_a[W-1:0];
                        r_dd   <= '0;
                        r_step <= '0;
                    end else begin
                        r_a   <= r_b;
                        r_b   <= r_a + r_b;
                        r_ctr <= r_ctr - NW'(1);
                    end
                end
                S_BIN2BCD: begin
                    r_dd   <= w_dd_next;
                    r_bin  <= r_bin << 1;
                    r_step <= r_step + SW'(1);
                    if (w_dd_last) begin
                        r_bcd  <= w_dd_next;
                        r_ovf  <= 1'b0;
                        r_errq <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o    = r_ready;
    assign done_o     = r_done;
    assign bcd_o      = r_bcd;
    assign overflow_o = r_ovf;
    assign error_o    = r_errq;

endmodule

// File: tb/tb_fibonacci_bcd_engine.sv
module tb_fibonacci_bcd_engine;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [7:0]  n_bcd_i;
    logic        ready_o, done_o, overflow_o, error_o;
    logic [15:0] bcd_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    fibonacci_bcd_engine #(.IN_DIGITS(2), .OUT_DIGITS(4)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .n_bcd_i    (n_bcd_i),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .bcd_o      (bcd_o),
        .overflow_o (overflow_o),
        .error_o    (error_o)
    );

    typedef struct {
        logic [7:0]  n;
        logic [15:0] bcd;
        logic        ovf;
        logic        err;
        int          idx;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Index 0 is the cycle after the start_i-sampling edge; outputs sampled on negedges.
    task automatic run_job(input logic [7:0] n, input logic [15:0] eb, input logic eo,
                           input logic ee, input int ei, input string tag);
        int idx;
        bit seen;
        @(negedge clk_i);
        chk({tag, " ready_idle"}, 32'(ready_o), 32'd1);
        start_i = 1'b1;
        n_bcd_i = n;
        @(negedge clk_i);
        start_i = 1'b0;
        n_bcd_i = ~n;
        chk({tag, " ready_busy"}, 32'(ready_o), 32'd0);
        idx  = 0;
        seen = 1'b0;
        while (!seen && idx < 200) begin
            if (done_o) seen = 1'b1;
            else begin
                @(negedge clk_i);
                idx++;
            end
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(idx), 32'(ei));
        chk({tag, " bcd"}, 32'(bcd_o), 32'(eb));
        chk({tag, " ovf"}, 32'(overflow_o), 32'(eo));
        chk({tag, " err"}, 32'(error_o), 32'(ee));
        chk({tag, " ready_in_done"}, 32'(ready_o), 32'd0);
        @(negedge clk_i);
        chk({tag, " done_pulse"}, 32'(done_o), 32'd0);
        chk({tag, " ready_after"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        int dcount;
        int didx;
        bit prev_done;

        vecs[0]  = '{8'h10, 16'h0055, 1'b0, 1'b0, 27};
        vecs[1]  = '{8'h00, 16'h0000, 1'b0, 1'b0, 17};
        vecs[2]  = '{8'h01, 16'h0001, 1'b0, 1'b0, 18};
        vecs[3]  = '{8'h20, 16'h6765, 1'b0, 1'b0, 37};
        vecs[4]  = '{8'h21, 16'h9999, 1'b1, 1'b0, 24};
        vecs[5]  = '{8'h99, 16'h9999, 1'b1, 1'b0, 24};
        vecs[6]  = '{8'h10, 16'h0055, 1'b0, 1'b0, 27};
        vecs[7]  = '{8'h1A, 16'h0055, 1'b0, 1'b1, 2};
        vecs[8]  = '{8'hA0, 16'h0055, 1'b0, 1'b1, 2};
        vecs[9]  = '{8'h07, 16'h0013, 1'b0, 1'b0, 24};
        vecs[10] = '{8'h12, 16'h0144, 1'b0, 1'b0, 29};

        reset_i = 1'b1;
        start_i = 1'b0;
        n_bcd_i = 8'h00;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst ready", 32'(ready_o), 32'd1);
        chk("rst done", 32'(done_o), 32'd0);
        chk("rst bcd", 32'(bcd_o), 32'h0);
        chk("rst ovf", 32'(overflow_o), 32'd0);
        chk("rst err", 32'(error_o), 32'd0);

        foreach (vecs[i])
            run_job(vecs[i].n, vecs[i].bcd, vecs[i].ovf, vecs[i].err, vecs[i].idx,
                    $sformatf("vec%0d", i));

        // Starts during FIB and during DONE must be dropped; n_bcd_i changes ignored.
        @(negedge clk_i);
        start_i = 1'b1;
        n_bcd_i = 8'h10;
        @(negedge clk_i);
        start_i   = 1'b0;
        dcount    = 0;
        didx      = -1;
        prev_done = 1'b0;
        for (int idx = 0; idx < 100; idx++) begin
            start_i = 1'b0;
            if (idx == 5) begin
                start_i = 1'b1;
                n_bcd_i = 8'h01;
            end
            if (idx == 7) n_bcd_i = 8'h33;
            if (done_o) begin
                dcount++;
                didx    = idx;
                start_i = 1'b1;
            end
            if (prev_done) start_i = 1'b0;
            prev_done = done_o;
            @(negedge clk_i);
        end
        start_i = 1'b0;
        chk("ign done_count", 32'(dcount), 32'd1);
        chk("ign latency", 32'(didx), 32'd27);
        chk("ign bcd", 32'(bcd_o), 32'h0055);
        chk("ign ready", 32'(ready_o), 32'd1);

        // Reset during FIB aborts the job and clears outputs immediately.
        @(negedge clk_i);
        start_i = 1'b1;
        n_bcd_i = 8'h20;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (6) @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        chk("mid rst ready", 32'(ready_o), 32'd1);
        chk("mid rst done", 32'(done_o), 32'd0);
        chk("mid rst bcd", 32'(bcd_o), 32'h0);
        chk("mid rst ovf", 32'(overflow_o), 32'd0);
        chk("mid rst err", 32'(error_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        run_job(8'h05, 16'h0005, 1'b0, 1'b0, 22, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
